// File: rtl/datapath_struct_29_if.sv
// Command/status bundle between controller_struct_29 and its datapath.
// Commands flow controller->datapath; A/E/F and observation flags flow back; no backpressure.
interface datapath_struct_29_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             clr_A;
  logic             ld_A;
  logic             inc_A;
  logic [WIDTH-1:0] din;
  logic             upd_E;
  logic             upd_F;
  logic             clr_flags;
  logic [WIDTH-1:0] A;
  logic             E;
  logic             F;
  logic             ovf;
  logic             cmd_err;
  logic [CNT_W-1:0] inc_cnt;

  modport master (
    output clr_A, ld_A, inc_A, din, upd_E, upd_F, clr_flags,
    input  A, E, F, ovf, cmd_err, inc_cnt
  );

  modport slave (
    input  clr_A, ld_A, inc_A, din, upd_E, upd_F, clr_flags,
    output A, E, F, ovf, cmd_err, inc_cnt
  );
endinterface

// File: rtl/datapath_struct_29.sv
// Executes controller register transfers on A and status flops E/F; all outputs are flops.
// One-cycle latency: commands sampled at edge N are visible after edge N; never stalls.
module datapath_struct_29 #(
  parameter int WIDTH = 4,
  parameter int E_BIT = 2,
  parameter int F_BIT = 3,
  parameter int CNT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  datapath_struct_29_if.slave    bus
);
  logic [WIDTH-1:0] r_a;
  logic             r_e;
  logic             r_f;
  logic             r_ovf;
  logic             r_cmd_err;
  logic [CNT_W-1:0] r_inc_cnt;

  logic w_ld_win;
  logic w_inc_win;
  logic w_conflict;
  logic w_a_max;
  logic w_cnt_max;

  // clr_A > ld_A > inc_A; only the winner acts on A, ovf and inc_cnt
  assign w_ld_win   = ~bus.clr_A & bus.ld_A;
  assign w_inc_win  = ~bus.clr_A & ~bus.ld_A & bus.inc_A;
  assign w_conflict = (bus.clr_A & bus.ld_A) | (bus.clr_A & bus.inc_A) |
                      (bus.ld_A & bus.inc_A);
  assign w_a_max    = (r_a == {WIDTH{1'b1}});
  assign w_cnt_max  = (r_inc_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a       <= '0;
      r_e       <= 1'b0;
      r_f       <= 1'b0;
      r_ovf     <= 1'b0;
      r_cmd_err <= 1'b0;
      r_inc_cnt <= '0;
    end else begin
      if (bus.clr_A)
        r_a <= '0;
      else if (w_ld_win)
        r_a <= bus.din;
      else if (w_inc_win)
        r_a <= r_a + WIDTH'(1);

      // E/F sample the pre-edge A, giving simultaneous-transfer semantics
      if (bus.clr_flags) begin
        r_e <= 1'b0;
        r_f <= 1'b0;
      end else begin
        if (bus.upd_E)
          r_e <= r_a[E_BIT];
        if (bus.upd_F)
          r_f <= r_a[F_BIT];
      end

      if (bus.clr_A || bus.clr_flags)
        r_ovf <= 1'b0;
      else if (w_inc_win && w_a_max)
        r_ovf <= 1'b1;

      r_cmd_err <= w_conflict;

      if (bus.clr_A)
        r_inc_cnt <= '0;
      else if (w_inc_win && !w_cnt_max)
        r_inc_cnt <= r_inc_cnt + CNT_W'(1);
    end
  end

  assign bus.A       = r_a;
  assign bus.E       = r_e;
  assign bus.F       = r_f;
  assign bus.ovf     = r_ovf;
  assign bus.cmd_err = r_cmd_err;
  assign bus.inc_cnt = r_inc_cnt;
endmodule

// File: tb/tb_datapath_struct_29.sv
// Directed bench: behavioural model of the register transfers plus hand-computed literal pins.
module tb_datapath_struct_29;
  localparam int WIDTH = 4;
  localparam int E_BIT = 2;
  localparam int F_BIT = 3;
  localparam int CNT_W = 4;
  localparam int A_MOD = 1 << WIDTH;
  localparam int C_MAX = (1 << CNT_W) - 1;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  // model state
  int m_a, m_e, m_f, m_ovf, m_err, m_cnt;

  datapath_struct_29_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  datapath_struct_29 #(
    .WIDTH(WIDTH), .E_BIT(E_BIT), .F_BIT(F_BIT), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_e = 0; m_f = 0; m_ovf = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".A"},       int'(bus.A),       m_a);
    chk({tag, ".E"},       int'(bus.E),       m_e);
    chk({tag, ".F"},       int'(bus.F),       m_f);
    chk({tag, ".ovf"},     int'(bus.ovf),     m_ovf);
    chk({tag, ".cmd_err"}, int'(bus.cmd_err), m_err);
    chk({tag, ".inc_cnt"}, int'(bus.inc_cnt), m_cnt);
  endtask

  // Apply one command set across one rising edge, advance the model, compare.
  task automatic cyc(input bit clr, input bit ld, input bit inc, input int din,
                     input bit ue, input bit uf, input bit cf, input string tag);
    int old_a;
    int n_cmd;
    bus.clr_A = clr; bus.ld_A = ld; bus.inc_A = inc; bus.din = din[WIDTH-1:0];
    bus.upd_E = ue; bus.upd_F = uf; bus.clr_flags = cf;
    @(posedge clock);
    old_a = m_a;
    n_cmd = int'(clr) + int'(ld) + int'(inc);
    if (clr)      m_a = 0;
    else if (ld)  m_a = din % A_MOD;
    else if (inc) m_a = (old_a + 1) % A_MOD;
    if (cf) begin
      m_e = 0; m_f = 0;
    end else begin
      if (ue) m_e = (old_a >> E_BIT) & 1;
      if (uf) m_f = (old_a >> F_BIT) & 1;
    end
    if (clr || cf)                                  m_ovf = 0;
    else if (!ld && inc && old_a == A_MOD - 1)      m_ovf = 1;
    m_err = (n_cmd >= 2) ? 1 : 0;
    if (clr)                                        m_cnt = 0;
    else if (!ld && inc && m_cnt < C_MAX)           m_cnt = m_cnt + 1;
    #1;
    cmp_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    bus.clr_A = 0; bus.ld_A = 0; bus.inc_A = 0; bus.din = '0;
    bus.upd_E = 0; bus.upd_F = 0; bus.clr_flags = 0;
    reset = 1'b0;
    #12;
    cmp_all("rst_init");
    reset = 1'b1;

    // 1: asynchronous reset mid-cycle with A=5, E=1
    cyc(0, 1, 0, 5, 0, 0, 0, "t1_ld5");
    cyc(0, 0, 0, 0, 1, 0, 0, "t1_updE");
    chk("t1_A_lit", int'(bus.A), 5);
    chk("t1_E_lit", int'(bus.E), 1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    cmp_all("t1_async");
    #2;
    reset = 1'b1;

    // 2: increments with upd_E sample pre-edge A
    cyc(1, 0, 0, 0, 0, 0, 0, "t2_clr");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1, 0, 0, $sformatf("t2_inc%0d", i));
    chk("t2_A_lit", int'(bus.A), 5);
    chk("t2_E_lit", int'(bus.E), 1);

    // 3: F follows old A[3]; rises after the 9th edge
    cyc(1, 0, 0, 0, 0, 0, 1, "t3_clr");
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 1, 0, $sformatf("t3_inc%0d", i));
    chk("t3_F_after8", int'(bus.F), 0);
    chk("t3_cnt8", int'(bus.inc_cnt), 8);
    cyc(0, 0, 1, 0, 0, 1, 0, "t3_inc8");
    chk("t3_F_after9", int'(bus.F), 1);
    chk("t3_cnt9", int'(bus.inc_cnt), 9);

    // 4: wrap sets sticky ovf; clr_flags clears it
    cyc(0, 1, 0, 15, 0, 0, 0, "t4_ldF");
    cyc(0, 0, 1, 0, 0, 0, 0, "t4_wrap");
    chk("t4_A_wrap", int'(bus.A), 0);
    chk("t4_ovf_set", int'(bus.ovf), 1);
    for (int i = 0; i < 3; i++) idle($sformatf("t4_hold%0d", i));
    chk("t4_ovf_held", int'(bus.ovf), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, "t4_clrf");
    chk("t4_ovf_clr", int'(bus.ovf), 0);
    // clear and set coinciding: clear wins
    cyc(0, 1, 0, 15, 0, 0, 0, "t4_ldF2");
    cyc(0, 0, 1, 0, 0, 0, 1, "t4_setclr");
    chk("t4_clr_wins", int'(bus.ovf), 0);

    // 5: conflicting commands
    cyc(0, 1, 0, 7, 0, 0, 0, "t5_ld7");
    cyc(0, 0, 1, 0, 0, 0, 0, "t5_inc");
    cyc(1, 0, 1, 0, 0, 0, 0, "t5_clr_inc");
    chk("t5_A0", int'(bus.A), 0);
    chk("t5_err", int'(bus.cmd_err), 1);
    chk("t5_cnt_clr", int'(bus.inc_cnt), 0);
    idle("t5_idle");
    chk("t5_err_pulse", int'(bus.cmd_err), 0);
    cyc(0, 1, 1, 9, 0, 0, 0, "t5_ld_inc");
    chk("t5_A9", int'(bus.A), 9);
    chk("t5_err2", int'(bus.cmd_err), 1);
    chk("t5_cnt_hold", int'(bus.inc_cnt), 0);
    cyc(1, 1, 1, 3, 0, 0, 0, "t5_all3");

    // 6: saturation, then a controller-style command walk
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0, 0, $sformatf("t6_inc%0d", i));
    chk("t6_sat", int'(bus.inc_cnt), 15);
    idle("t6_hold");
    chk("t6_sat_hold", int'(bus.inc_cnt), 15);
    cyc(1, 0, 0, 0, 0, 0, 1, "t6_s0");
    cyc(0, 0, 1, 0, 1, 1, 0, "t6_s2");
    cyc(0, 1, 0, 12, 0, 0, 0, "t6_s4");
    cyc(0, 0, 1, 0, 1, 1, 0, "t6_s6");
    chk("t6_E_lit", int'(bus.E), 1);
    chk("t6_F_lit", int'(bus.F), 1);
    cyc(0, 0, 0, 0, 1, 1, 0, "t6_s7");
    cyc(0, 0, 0, 0, 1, 1, 1, "t6_back");
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 1, 0, i[0], ~i[0], 0, $sformatf("t6_mix%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
